// File: rtl/brightness_pkg.sv
// Shared widths, state encoding and result types for the brightness/contrast MAC stage.
// Also holds the fixed-point round-and-scale helper used by the second pipeline stage.
package brightness_pkg;

    localparam int PIX_W     = 8;
    localparam int GAIN_W    = 12;
    localparam int FRAC_BITS = 8;
    localparam int OFS_W     = 16;
    localparam int OUT_W     = 24;
    localparam int PROD_W    = PIX_W + GAIN_W + 1;

    localparam logic signed [GAIN_W-1:0] GAIN_ONE   = GAIN_W'(12'h100);
    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(2 ** (FRAC_BITS - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bmac_state_t;

    typedef logic signed [OUT_W-1:0]  bmac_res_t;
    typedef logic signed [PROD_W-1:0] bmac_prod_t;

    // S1 carries the offset next to the product so each pixel keeps the offset
    // that was active when it was accepted.
    typedef struct packed {
        bmac_prod_t               prod;
        logic signed [OFS_W-1:0]  offset;
    } s1_dat_t;

    // Round half up, then arithmetic shift; result sign-extended to OUT_W.
    function automatic bmac_res_t round_scale(input bmac_prod_t prod);
        bmac_prod_t rsum;
        bmac_prod_t rshift;
        rsum   = prod + ROUND_HALF;
        rshift = rsum >>> FRAC_BITS;
        return {{(OUT_W - PROD_W){rshift[PROD_W-1]}}, rshift};
    endfunction

endpackage

// File: rtl/brightness_pipe_reg.sv
// Purpose: one valid/data/last pipeline register stage with an advance enable.
// Latency: 1 cycle from load to output.
// Backpressure: holds contents whenever adv is low; caller derives adv from downstream ready.
module brightness_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         in_last,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         out_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
        end else if (adv) begin
            out_vld <= in_vld;
            // Bubbles leave the data alone so the last result stays on the bus.
            if (in_vld) begin
                out_dat  <= in_dat;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/brightness_mac_stage.sv
// Purpose: per-pixel round(pix*gain)+offset with frame-atomic gain/offset, feeding the clamp normalizer.
// Latency: 2 cycles (S1 product, S2 scaled sum), throughput 1 pixel/clk.
// Backpressure: two-stage skid-free valid/ready; in_ready forced low while a frame's tail drains.
module brightness_mac_stage
    import brightness_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic signed [GAIN_W-1:0] cfg_gain,
    input  logic signed [OFS_W-1:0]  cfg_offset,
    output logic                     cfg_pending,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pix,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_value,
    output logic                     out_last,
    output logic                     busy
);

    bmac_state_t state_q;
    bmac_state_t state_d;

    logic signed [GAIN_W-1:0] act_gain;
    logic signed [OFS_W-1:0]  act_ofs;
    logic signed [GAIN_W-1:0] shd_gain;
    logic signed [OFS_W-1:0]  shd_ofs;

    logic adv1;
    logic adv2;
    logic accept;
    logic out_fire;
    logic drain_done;

    s1_dat_t   s1_in;
    s1_dat_t   s1_dat;
    logic      s1_vld;
    logic      s1_last;
    bmac_res_t s2_in;
    logic [OUT_W-1:0] s2_dat;
    logic      s2_vld;
    logic      s2_last;

    bmac_prod_t pix_ext;
    bmac_prod_t gain_ext;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign adv2       = !s2_vld || out_ready;
    assign adv1       = !s1_vld || adv2;
    assign in_ready   = adv1 && (state_q != DRAIN);
    assign accept     = in_valid && in_ready;
    assign out_fire   = s2_vld && out_ready;
    assign drain_done = (state_q == DRAIN) && out_fire && s2_last;

    // ------------------------------------------------------------------
    // Arithmetic: the 21-bit product of a 9-bit non-negative pixel and a
    // 12-bit signed gain cannot overflow.
    // ------------------------------------------------------------------
    assign pix_ext  = PROD_W'({1'b0, in_pix});
    assign gain_ext = PROD_W'(act_gain);

    always_comb begin
        s1_in        = '0;
        s1_in.prod   = pix_ext * gain_ext;
        s1_in.offset = act_ofs;
    end

    assign s2_in = round_scale(s1_dat.prod)
                 + {{(OUT_W - OFS_W){s1_dat.offset[OFS_W-1]}}, s1_dat.offset};

    brightness_pipe_reg #(
        .W ($bits(s1_dat_t))
    ) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv1),
        .in_vld   (accept),
        .in_dat   (s1_in),
        .in_last  (in_last),
        .out_vld  (s1_vld),
        .out_dat  (s1_dat),
        .out_last (s1_last)
    );

    brightness_pipe_reg #(
        .W (OUT_W)
    ) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv2),
        .in_vld   (s1_vld),
        .in_dat   (s2_in),
        .in_last  (s1_last),
        .out_vld  (s2_vld),
        .out_dat  (s2_dat),
        .out_last (s2_last)
    );

    assign out_valid = s2_vld;
    assign out_value = s2_dat;
    assign out_last  = s2_last;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration: direct in an idle cycle, otherwise shadowed until the
    // frame's last result leaves.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_gain    <= GAIN_ONE;
            act_ofs     <= '0;
            shd_gain    <= GAIN_ONE;
            shd_ofs     <= '0;
            cfg_pending <= 1'b0;
        end else if (drain_done) begin
            // A write on the frame-end edge is newer than the shadow, so it wins.
            if (cfg_we) begin
                act_gain <= cfg_gain;
                act_ofs  <= cfg_offset;
            end else if (cfg_pending) begin
                act_gain <= shd_gain;
                act_ofs  <= shd_ofs;
            end
            cfg_pending <= 1'b0;
        end else if (cfg_we) begin
            if ((state_q == IDLE) && !accept) begin
                act_gain <= cfg_gain;
                act_ofs  <= cfg_offset;
            end else begin
                shd_gain    <= cfg_gain;
                shd_ofs     <= cfg_offset;
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_brightness_mac_stage.sv
// Directed bench for brightness_mac_stage: expected results queued at pixel accept, checked at output transfer.
module tb_brightness_mac_stage;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [11:0] cfg_gain;
    logic [15:0] cfg_offset;
    logic        cfg_pending;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pix;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_value;
    logic        out_last;
    logic        busy;

    typedef struct packed {
        logic [23:0] val;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [11:0] m_gain;
    logic [15:0] m_ofs;
    int          n_vec = 0;
    int          n_err = 0;

    brightness_mac_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_gain    (cfg_gain),
        .cfg_offset  (cfg_offset),
        .cfg_pending (cfg_pending),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pix      (in_pix),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_last    (out_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: round-half-up of pix*gain/256 plus offset, wrapped to 24 bits.
    function automatic logic [23:0] model(input logic [7:0] pix, input logic [11:0] g, input logic [15:0] o);
        int gi;
        int oi;
        int p;
        int r;
        gi = int'($signed(g));
        oi = int'($signed(o));
        p  = int'(pix) * gi;
        r  = (p + 128) >>> 8;
        return 24'(r + oi);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [11:0] g, input logic [15:0] o);
        cfg_we     = 1'b1;
        cfg_gain   = g;
        cfg_offset = o;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [7:0] pix, input logic last);
        logic ok;
        exp_t e;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_pix   = pix;
        in_last  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.val  = model(pix, m_gain, m_ofs);
                e.last = last;
                sb.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) done = 1'b1;
        end
        @(posedge clk);
        #1;
        check("drain_complete", 32'(done), 32'd1);
    endtask

    task automatic frame1(input logic [11:0] g, input logic [15:0] o, input logic [7:0] pix);
        cfg_write(g, o);
        m_gain = g;
        m_ofs  = o;
        send(pix, 1'b1);
        wait_idle();
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_value", 32'(out_value), 32'(mon_e.val));
                check("out_last", 32'(out_last), 32'(mon_e.last));
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_gain   = '0;
        cfg_offset = '0;
        in_valid   = 1'b0;
        in_pix     = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        m_gain     = 12'h100;
        m_ofs      = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_value", 32'(out_value), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_cfg_pending", 32'(cfg_pending), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // T1 identity with offset, and two-cycle latency
        cfg_write(12'h100, 16'd20);
        m_gain = 12'h100;
        m_ofs  = 16'd20;
        send(8'd100, 1'b1);
        @(negedge clk);
        check("t1_lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_lat_cycle2", 32'(out_valid), 32'd1);
        check("t1_value", 32'(out_value), 32'd120);
        @(posedge clk);
        #1;
        wait_idle();

        // T2 sign paths, T3 rounding, extremes, negative offset
        frame1(12'h200, 16'h0000, 8'd200);
        frame1(12'hF00, 16'h0000, 8'd10);
        frame1(12'h080, 16'h0000, 8'd3);
        frame1(12'h080, 16'h0000, 8'd1);
        frame1(12'h055, 16'h0000, 8'd1);
        frame1(12'h7FF, 16'h0000, 8'd255);
        frame1(12'h800, 16'h0000, 8'd255);
        frame1(12'h100, 16'h8000, 8'd7);

        // T4 backpressure: two accepts fill S1/S2, then outputs must hold
        cfg_write(12'h100, 16'h0000);
        m_gain    = 12'h100;
        m_ofs     = 16'h0000;
        out_ready = 1'b0;
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        in_valid = 1'b1;
        in_pix   = 8'd30;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_in_ready_low", 32'(in_ready), 32'd0);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_value", 32'(out_value), 32'(model(8'd10, m_gain, m_ofs)));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'd30, 1'b0);
        send(8'd40, 1'b1);
        wait_idle();

        // T5 deferred config mid-frame
        cfg_write(12'h100, 16'd5);
        m_gain = 12'h100;
        m_ofs  = 16'd5;
        send(8'd11, 1'b0);
        send(8'd22, 1'b0);
        cfg_write(12'h200, 16'hFFFD);
        @(negedge clk);
        check("t5_pending_set", 32'(cfg_pending), 32'd1);
        check("t5_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        send(8'd33, 1'b0);
        send(8'd44, 1'b1);
        @(negedge clk);
        check("t5_drain_in_ready", 32'(in_ready), 32'd0);
        check("t5_pending_drain", 32'(cfg_pending), 32'd1);
        @(posedge clk);
        #1;
        wait_idle();
        @(negedge clk);
        check("t5_pending_clear", 32'(cfg_pending), 32'd0);
        @(posedge clk);
        #1;
        m_gain = 12'h200;
        m_ofs  = 16'hFFFD;
        send(8'd50, 1'b1);
        wait_idle();

        // T6 asynchronous reset with both stages full
        cfg_write(12'h180, 16'd7);
        m_gain    = 12'h180;
        m_ofs     = 16'd7;
        out_ready = 1'b0;
        send(8'd60, 1'b0);
        send(8'd70, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_out_value", 32'(out_value), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        m_gain    = 12'h100;
        m_ofs     = 16'h0000;
        send(8'd77, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
